// File: rtl/mips_mem_pkg.sv
// Shared types and decode helpers for the data-memory load/store path.
// Pure definitions; no latency or flow control of its own.
package mips_mem_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LBU = 3'd1,
        LH  = 3'd2,
        LHU = 3'd3,
        LW  = 3'd4,
        SB  = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        RMW_WRITE = 2'd2,
        RESP      = 2'd3
    } lsu_state_t;

    function automatic logic is_load(input mem_op_t op);
        return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
    endfunction

    function automatic logic is_subword_store(input mem_op_t op);
        return (op == SB) || (op == SH);
    endfunction

    // Halves need an even byte offset, words need offset zero.
    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if ((op == LH) || (op == LHU) || (op == SH)) bad = off[0];
        if ((op == LW) || (op == SW))                bad = (off != 2'b00);
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
// Purely combinational, zero latency, no flow control.
module lsu_align
    import mips_mem_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  byte_off,
    input  logic [31:0] word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[8*byte_off +: 8];
        half_sel = byte_off[1] ? word[31:16] : word[15:0];

        load_data = word;
        unique case (op)
            LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     load_data = {24'h0, byte_sel};
            LH:      load_data = {{16{half_sel[15]}}, half_sel};
            LHU:     load_data = {16'h0, half_sel};
            default: load_data = word;
        endcase

        merged_word = store_data;
        if (op == SB) begin
            merged_word = word;
            merged_word[8*byte_off +: 8] = store_data[7:0];
        end else if (op == SH) begin
            merged_word = word;
            if (byte_off[1]) merged_word[31:16] = store_data[15:0];
            else             merged_word[15:0]  = store_data[15:0];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding data-memory initiator: loads/SW respond at T+2, SB/SH (read-modify-write) at T+3, errors at T+1.
// req_ready is high only in IDLE; the one-cycle response pulse has no backpressure.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        req_valid,
    output logic        req_ready,
    input  mem_op_t     req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wrData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] mem_readData
);

    lsu_state_t  state, state_nx;
    mem_op_t     op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] merged_q;
    logic        err_q;

    logic        accept;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign accept  = req_valid && req_ready;
    assign req_err = is_misaligned(req_op, req_addr[1:0]) ||
                     ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

    // Address is held from acceptance, so it is stable across ACCESS and RMW_WRITE.
    assign mem_address = {2'b00, addr_q[31:2]};

    lsu_align u_align (
        .op          (op_q),
        .byte_off    (addr_q[1:0]),
        .word        (mem_readData),
        .store_data  (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            op_q     <= LB;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            merged_q <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= req_err;
                rdata_q <= 32'h0;
            end
            if (state == ACCESS) begin
                if (is_load(op_q))          rdata_q  <= load_data;
                if (is_subword_store(op_q)) merged_q <= merged_word;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        mem_wrData = 32'h0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_err   = 1'b0;

        unique case (state)
            IDLE: begin
                // Held low during reset even though state already sits in IDLE.
                req_ready = resetN;
                if (req_valid && resetN) state_nx = req_err ? RESP : ACCESS;
            end
            ACCESS: begin
                if (op_q == SW) begin
                    MemWrite   = 1'b1;
                    mem_wrData = wdata_q;
                    state_nx   = RESP;
                end else if (is_subword_store(op_q)) begin
                    MemRead  = 1'b1;
                    state_nx = RMW_WRITE;
                end else begin
                    MemRead  = 1'b1;
                    state_nx = RESP;
                end
            end
            RMW_WRITE: begin
                MemWrite   = 1'b1;
                mem_wrData = merged_q;
                state_nx   = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = err_q ? 32'h0 : rdata_q;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory model and a response scoreboard.
module tb_load_store_unit;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        req_valid;
    logic        req_ready;
    mem_op_t     req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_wrData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_readData;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_address  (mem_address),
        .mem_wrData   (mem_wrData),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .mem_readData (mem_readData)
    );

    logic [31:0] mem [0:255];
    assign mem_readData = mem[mem_address[7:0]];
    always @(posedge clk) if (MemWrite) mem[mem_address[7:0]] <= mem_wrData;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          at;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on each pulse, checks quiet outputs otherwise.
    always @(negedge clk) begin
        if (resetN) begin
            chk("strobe_exclusive", {31'h0, MemRead & MemWrite}, 32'h0);
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $error("FAIL unexpected_resp: observed rdata %h err %b expected no response", resp_rdata, resp_err);
                end else begin
                    e = sb.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                    chk("resp_cycle", cyc, e.at);
                end
            end else begin
                chk("quiet_rdata", resp_rdata, 32'h0);
                chk("quiet_err", {31'h0, resp_err}, 32'h0);
            end
        end
    end

    task automatic issue(input mem_op_t op, input logic [31:0] a, input logic [31:0] w,
                         input logic [31:0] er, input logic ee, input int lat, input bit push);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_bad++;
            $error("FAIL ready_timeout: observed req_ready 0 expected 1");
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = w;
        if (push) sb.push_back('{er, ee, cyc + lat});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        int n;
        req_valid = 1'b0;
        req_op    = LB;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_memread", {31'h0, MemRead}, 32'h0);
        chk("rst_memwrite", {31'h0, MemWrite}, 32'h0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_mem_wrdata", mem_wrData, 32'h0);
        resetN = 1'b1;
        @(negedge clk);
        chk("idle_ready", {31'h0, req_ready}, 32'h1);

        // Full-word store and its bus cycle.
        issue(SW, 32'h0C, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
        chk("sw_memwrite", {31'h0, MemWrite}, 32'h1);
        chk("sw_memread", {31'h0, MemRead}, 32'h0);
        chk("sw_address", mem_address, 32'd3);
        chk("sw_wrdata", mem_wrData, 32'hDEADBEEF);

        // Sub-word loads with sign/zero extension.
        issue(LB, 32'h0F, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 1'b1);
        chk("lb_memread", {31'h0, MemRead}, 32'h1);
        chk("lb_memwrite", {31'h0, MemWrite}, 32'h0);
        issue(LBU, 32'h0F, 32'h0, 32'h000000DE, 1'b0, 2, 1'b1);
        issue(LH, 32'h0E, 32'h0, 32'hFFFFDEAD, 1'b0, 2, 1'b1);
        issue(LHU, 32'h0C, 32'h0, 32'h0000BEEF, 1'b0, 2, 1'b1);
        issue(LW, 32'h0C, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1);

        // Byte store as read-modify-write.
        issue(SB, 32'h0D, 32'h00000012, 32'h0, 1'b0, 3, 1'b1);
        chk("sb_memread", {31'h0, MemRead}, 32'h1);
        chk("sb_read_memwrite", {31'h0, MemWrite}, 32'h0);
        @(negedge clk);
        chk("sb_memwrite", {31'h0, MemWrite}, 32'h1);
        chk("sb_write_memread", {31'h0, MemRead}, 32'h0);
        chk("sb_wrdata", mem_wrData, 32'hDEAD12EF);
        chk("sb_address", mem_address, 32'd3);
        issue(LW, 32'h0C, 32'h0, 32'hDEAD12EF, 1'b0, 2, 1'b1);
        issue(LHU, 32'h0E, 32'h0, 32'h0000DEAD, 1'b0, 2, 1'b1);

        // Misaligned and out-of-range requests.
        issue(LW, 32'h0E, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        chk("err_lw_strobes", {30'h0, MemRead, MemWrite}, 32'h0);
        issue(SH, 32'h0D, 32'h1234, 32'h0, 1'b1, 1, 1'b1);
        chk("err_sh_strobes", {30'h0, MemRead, MemWrite}, 32'h0);
        issue(LW, 32'h400, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        chk("err_oor_strobes", {30'h0, MemRead, MemWrite}, 32'h0);
        issue(LBU, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        issue(LB, 32'h3FF, 32'h0, 32'h0, 1'b0, 2, 1'b1);

        // Back-to-back stores with req_valid held high.
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        req_op    = SW;
        req_addr  = 32'h20;
        req_wdata = 32'hA5A50001;
        sb.push_back('{32'h0, 1'b0, cyc + 2});
        @(negedge clk);
        chk("b2b_ready_t1", {31'h0, req_ready}, 32'h0);
        req_wdata = 32'h5A5A0002;
        @(negedge clk);
        chk("b2b_ready_t2", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        chk("b2b_ready_t3", {31'h0, req_ready}, 32'h1);
        sb.push_back('{32'h0, 1'b0, cyc + 2});
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_second_accepted", {31'h0, req_ready}, 32'h0);
        issue(LW, 32'h20, 32'h0, 32'h5A5A0002, 1'b0, 2, 1'b1);

        // Reset during a half-word store's read phase.
        issue(SW, 32'h10, 32'h11223344, 32'h0, 1'b0, 2, 1'b1);
        issue(SH, 32'h10, 32'h0000BEEF, 32'h0, 1'b0, 0, 1'b0);
        chk("rmw_reset_memread_before", {31'h0, MemRead}, 32'h1);
        resetN = 1'b0;
        #1;
        chk("rmw_reset_strobes", {30'h0, MemRead, MemWrite}, 32'h0);
        chk("rmw_reset_ready", {31'h0, req_ready}, 32'h0);
        chk("rmw_reset_address", mem_address, 32'h0);
        chk("rmw_reset_resp", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        chk("rmw_reset_held_strobes", {30'h0, MemRead, MemWrite}, 32'h0);
        resetN = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", {31'h0, req_ready}, 32'h1);
        issue(LW, 32'h10, 32'h0, 32'h11223344, 1'b0, 2, 1'b1);

        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
